// File: rtl/act_pkg.sv
// Shared FSM state type and Q8.8 dequantization constants for the activation path.
// Pure declarations: no latency and no flow control of its own.
package act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DQ_FRAC_BITS = 8;
    localparam int DQ_ROUND     = 128;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: a write becomes visible on rd_vld/rd_dat one cycle later.
// Head entry holds while rd_rdy is low; writes while full are dropped, so the producer must bound its fill level.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign do_wr  = wr_vld && (cnt_q != CNT_W'(DEPTH));
    assign do_rd  = rd_rdy && (cnt_q != '0);
    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ub_dequant_reader.sv
// Streams int8 UB data out as int32 ((q - zp) * S + 0.5) >> 8; out_valid follows a read by 5 cycles.
// Reads stall while FIFO_DEPTH elements are outstanding, so out_ready backpressure never overflows the FIFO.
module ub_dequant_reader #(
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   length,
    input  logic signed [15:0] dq_scale,
    input  logic signed [7:0]  dq_zero_point,
    output logic               ub_rd_en,
    output logic [ADDR_W-1:0]  ub_rd_addr,
    input  logic signed [7:0]  ub_rd_data,
    output logic               out_valid,
    output logic signed [31:0] out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);
    import act_pkg::*;

    localparam int OUT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       scale_q, scale_d;
    logic [7:0]        zp_q, zp_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              done_q, done_d;
    logic [3:0]        pv_q, pv_d;
    logic [3:0]        pl_q, pl_d;
    logic [8:0]        diff_q, diff_d;
    logic [24:0]       prod_q, prod_d;
    logic [31:0]       res_q, res_d;
    logic [24:0]       rnd_sum;
    logic              issue, issue_last, accept;
    logic [32:0]       fifo_dat;

    // Outstanding covers pipeline plus FIFO, so capping it at FIFO_DEPTH keeps the FIFO from overflowing.
    assign issue      = (state_q == ISSUE) && (outst_q < OUT_W'(FIFO_DEPTH));
    assign issue_last = issue && (cnt_q == len_q - LEN_W'(1));
    assign accept     = out_valid && out_ready;
    assign rnd_sum    = prod_q + 25'(DQ_ROUND);

    assign ub_rd_en   = issue;
    assign ub_rd_addr = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        scale_d = scale_q;
        zp_d    = zp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    len_d   = length;
                    scale_d = dq_scale;
                    zp_d    = dq_zero_point;
                    cnt_d   = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        outst_d = outst_q + OUT_W'(issue) - OUT_W'(accept);

        // pv/pl bit 0 tags the returning read data, bits 1..3 the diff, prod and result stages.
        pv_d   = {pv_q[2:0], issue};
        pl_d   = {pl_q[2:0], issue_last};
        diff_d = {ub_rd_data[7], ub_rd_data} - {zp_q[7], zp_q};
        prod_d = {{16{diff_q[8]}}, diff_q} * {{9{scale_q[15]}}, scale_q};
        res_d  = {{(32 - 25 + DQ_FRAC_BITS){rnd_sum[24]}}, rnd_sum[24:DQ_FRAC_BITS]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            scale_q <= '0;
            zp_q    <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
            pv_q    <= '0;
            pl_q    <= '0;
            diff_q  <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
            zp_q    <= zp_d;
            outst_q <= outst_d;
            done_q  <= done_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            diff_q  <= diff_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
        end
    end

    sync_fifo #(
        .WIDTH(33),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (pv_q[3]),
        .wr_dat ({pl_q[3], res_q}),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (fifo_dat)
    );

    assign out_data = fifo_dat[31:0];
    assign out_last = fifo_dat[32];

endmodule

// File: tb/tb_ub_dequant_reader.sv
// Randomized scoreboard bench for ub_dequant_reader with a behavioural UB memory and dequant model.
`timescale 1ns/1ps
module tb_ub_dequant_reader;
    localparam int ADDR_W     = 8;
    localparam int LEN_W      = 9;
    localparam int FIFO_DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [LEN_W-1:0]   length = '0;
    logic signed [15:0] dq_scale = '0;
    logic signed [7:0]  dq_zero_point = '0;
    logic               ub_rd_en;
    logic [ADDR_W-1:0]  ub_rd_addr;
    logic signed [7:0]  ub_rd_data = '0;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               out_last;
    logic               out_ready = 1'b1;
    logic               busy;
    logic               done;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t       exp_q[$];
    int         addr_q[$];
    logic [7:0] ub_mem [256];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         ready_mode = 1;   // 0 random, 1 always high, 2 always low

    // monitor state
    exp_t  e;
    int    tb_outst = 0;
    int    rd_total = 0;
    int    rd_cyc = 0;
    int    valid_rise_cyc = 0;
    int    acc_first = 0;
    int    acc_last = 0;
    int    last_acc_data = 0;
    bit    new_xfer = 1;
    bit    prev_valid = 0;
    bit    stalled = 0;
    bit    done_exp = 0;
    bit    done_nxt;
    bit    acc;
    int    held_data = 0;
    bit    held_last = 0;

    ub_dequant_reader #(
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .dq_scale      (dq_scale),
        .dq_zero_point (dq_zero_point),
        .ub_rd_en      (ub_rd_en),
        .ub_rd_addr    (ub_rd_addr),
        .ub_rd_data    (ub_rd_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: floor(((q - zp) * S + 128) / 256), no saturation.
    function automatic int dq_model(input int q, input int zp, input int s);
        int p;
        int r;
        p = (q - zp) * s + 128;
        r = p / 256;
        if ((p % 256) != 0 && p < 0) r = r - 1;
        return r;
    endfunction

    // UB model: data valid during the cycle after the read strobe; garbage otherwise.
    logic             cap_en;
    logic [ADDR_W-1:0] cap_addr;
    always begin
        @(negedge clk);
        cap_en   = ub_rd_en;
        cap_addr = ub_rd_addr;
        @(posedge clk);
        #1;
        ub_rd_data = cap_en ? $signed(ub_mem[cap_addr]) : $signed(8'($urandom));
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            tb_outst = 0;
            done_exp = 0;
            stalled = 0;
            prev_valid = 0;
            new_xfer = 1;
        end else begin
            acc = out_valid && out_ready;
            if (done || done_exp) chk("done_pulse", done, done_exp);
            done_nxt = start && (length == '0) && !busy;
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_data);
                chk("hold_last", out_last, held_last);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = out_valid;
            if (ub_rd_en) begin
                rd_cyc = cyc;
                rd_total++;
                chk("outstanding_below_depth", (tb_outst < FIFO_DEPTH), 1);
                if (addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_read: got addr %0d, expected no read", ub_rd_addr);
                end else begin
                    chk("rd_addr", ub_rd_addr, addr_q.pop_front());
                end
            end
            tb_outst = tb_outst + (ub_rd_en ? 1 : 0) - (acc ? 1 : 0);
            if (acc) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0d, expected no element", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    last_acc_data = out_data;
                    if (new_xfer) acc_first = cyc;
                    new_xfer = 0;
                    if (e.last) begin
                        acc_last = cyc;
                        new_xfer = 1;
                        done_nxt = 1;
                    end
                end
            end
            done_exp = done_nxt;
        end
    end

    task automatic fill_rand(input logic [7:0] b, input int len);
        for (int i = 0; i < len; i++) ub_mem[8'(b + i)] = 8'($urandom);
    endtask

    task automatic push_exp(input logic [7:0] b, input int len,
                            input logic signed [15:0] s, input logic signed [7:0] z);
        logic [7:0] a;
        for (int i = 0; i < len; i++) begin
            a = 8'(b + i);
            addr_q.push_back(int'(a));
            exp_q.push_back('{dq_model(int'($signed(ub_mem[a])), int'(z), int'(s)), (i == len - 1)});
        end
    endtask

    task automatic pulse_start(input logic [7:0] b, input int len,
                               input logic signed [15:0] s, input logic signed [7:0] z);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = LEN_W'(len);
        dq_scale = s;
        dq_zero_point = z;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 8'($urandom);
        length = LEN_W'($urandom);
        dq_scale = 16'($urandom);
        dq_zero_point = 8'($urandom);
    endtask

    task automatic wait_done(output int n);
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 3000) chk("done_timeout", 0, 1);
    endtask

    task automatic post_check();
        repeat (3) @(negedge clk);
        chk("all_delivered", exp_q.size(), 0);
        chk("all_reads_seen", addr_q.size(), 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_xfer(input logic [7:0] b, input int len, input logic signed [15:0] s,
                            input logic signed [7:0] z, input bit poke, output int n);
        push_exp(b, len, s, z);
        pulse_start(b, len, s, z);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("busy_mid_xfer", busy, 1);
            pulse_start(8'(b + 37), 5, -s, 8'(z + 1));
        end
        wait_done(n);
        post_check();
    endtask

    initial begin
        int n;
        int r0;
        bit seen;
        for (int i = 0; i < 256; i++) ub_mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ub_rd_en", ub_rd_en, 0);
        chk("rst_ub_rd_addr", ub_rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed: UB[0x10]=10, zp=2, S=1.5 -> 12 with 5-cycle latency
        ub_mem[8'h10] = 8'd10;
        run_xfer(8'h10, 1, 16'sh0180, 8'sd2, 0, n);
        chk("req032_value", last_acc_data, 12);
        chk("req032_latency", valid_rise_cyc - rd_cyc, 5);

        // Extreme values of diff and scale
        ub_mem[8'h20] = 8'h80;
        run_xfer(8'h20, 1, 16'sh7FFF, 8'sd127, 0, n);
        chk("req033_neg", last_acc_data, -32639);
        ub_mem[8'h21] = 8'h7F;
        run_xfer(8'h21, 1, 16'sh7FFF, -8'sd128, 0, n);
        chk("req033_pos", last_acc_data, 32639);

        // Address wrap
        fill_rand(8'hFE, 4);
        run_xfer(8'hFE, 4, 16'sh0100, 8'sd0, 0, n);

        // Sustained rate with ready held high
        fill_rand(8'h40, 20);
        run_xfer(8'h40, 20, 16'sh00C3, -8'sd7, 0, n);
        chk("throughput_20", acc_last - acc_first, 19);

        // Random backpressure plus a start while busy
        ready_mode = 0;
        fill_rand(8'h60, 20);
        run_xfer(8'h60, 20, 16'shFE37, 8'sd13, 1, n);

        // Zero-length transfer
        ready_mode = 1;
        r0 = rd_total;
        pulse_start(8'h33, 0, 16'sh0100, 8'sd0);
        wait_done(n);
        chk("len0_done_next_cycle", n, 0);
        post_check();
        chk("len0_no_reads", rd_total - r0, 0);

        // Outstanding cap with the consumer stalled
        ready_mode = 2;
        fill_rand(8'h80, 12);
        push_exp(8'h80, 12, 16'sh0233, 8'sd5);
        r0 = rd_total;
        pulse_start(8'h80, 12, 16'sh0233, 8'sd5);
        repeat (20) @(negedge clk);
        chk("outstanding_cap", rd_total - r0, FIFO_DEPTH);
        ready_mode = 1;
        wait_done(n);
        post_check();

        // Random transfers
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            int len;
            ready_mode = 0;
            b = 8'($urandom);
            len = $urandom_range(1, 40);
            fill_rand(b, len);
            run_xfer(b, len, 16'($urandom), 8'($urandom), 0, n);
        end

        // Reset while draining
        ready_mode = 2;
        fill_rand(8'hC0, 6);
        push_exp(8'hC0, 6, 16'sh0100, 8'sd0);
        pulse_start(8'hC0, 6, 16'sh0100, 8'sd0);
        repeat (14) @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        seen = done;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        ready_mode = 1;
        fill_rand(8'hC8, 9);
        run_xfer(8'hC8, 9, 16'shFF80, -8'sd3, 0, n);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ub_dequant_reader.md
UB_DEQUANT_READER -- requirements
Module: ub_dequant_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the unified-buffer address width.
REQ-002 SHALL have parameter LEN_W, default 9, meaning the transfer-length width in elements.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the output FIFO depth (power of 2, at least 8).
REQ-004 SHALL have port clk, input, 1, meaning the clock.
REQ-005 SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, ADDR_W, meaning the first UB address to read.
REQ-008 SHALL have port length, input, LEN_W, meaning the number of int8 elements to read.
REQ-009 SHALL have port dq_scale, input, 16 signed, meaning the scale S in Q8.8.
REQ-010 SHALL have port dq_zero_point, input, 8 signed, meaning the zero point.
REQ-011 SHALL have port ub_rd_en, output, 1, meaning the UB read strobe.
REQ-012 SHALL have port ub_rd_addr, output, ADDR_W, meaning the UB read address.
REQ-013 SHALL have port ub_rd_data, input, 8 signed, meaning UB read data, valid exactly 1 cycle after ub_rd_en.
REQ-014 SHALL have output ports out_valid (1), out_data (32 signed) and out_last (1), meaning the dequantized stream and its final-element flag.
REQ-015 SHALL have port out_ready, input, 1, meaning consumer acceptance.
REQ-016 SHALL have output ports busy (1) and done (1), meaning transfer in progress and a one-cycle completion pulse.

Function
REQ-017 SHALL latch base_addr, length, dq_scale and dq_zero_point only when start is sampled in IDLE; start SHALL be ignored in any other state.
REQ-018 SHALL implement the FSM IDLE->ISSUE on start with length>0, ISSUE->DRAIN after the length-th read issues, and DRAIN->IDLE on the cycle the out_last element is accepted.
REQ-019 SHALL, on start with length==0, stay in IDLE, issue no reads, and pulse done on the following cycle.
REQ-020 SHALL issue reads at incrementing addresses from base_addr, at most one per cycle, wrapping modulo 2^ADDR_W.
REQ-021 SHALL issue a read only while outstanding < FIFO_DEPTH, where outstanding = reads issued - elements accepted; reads SHALL never overflow the FIFO.
REQ-022 SHALL compute diff = ub_rd_data - zero_point as 9-bit signed, then prod = diff * scale as 25-bit signed, then result = (prod + 128) >>> 8, sign-extended to 32 bits with no saturation.
REQ-023 SHALL use 3 register stages for REQ-022 (diff, prod, round/shift) before the FIFO write.
REQ-024 SHALL assert out_valid, with out_ready held high and the FIFO empty, in cycle t+5 for a read issued in cycle t, and SHALL sustain 1 element per cycle.
REQ-025 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL assert out_last only on element number length, with exactly length elements delivered in order.
REQ-027 SHALL pulse done for 1 cycle after the out_last handshake, and SHALL assert busy in ISSUE and DRAIN.

Reset
REQ-028 SHALL, on reset, enter IDLE, empty the FIFO, clear all counters and pipeline valids, and drive ub_rd_en, out_valid, out_last, busy and done to 0 and ub_rd_addr and out_data to 0.
REQ-029 SHALL, on reset mid-transfer, abort the transfer and discard all in-flight data, with no done pulse.

Structure
REQ-030 SHALL place the state enum (IDLE/ISSUE/DRAIN), DQ_FRAC_BITS=8 and DQ_ROUND=128 in the shared package act_pkg.
REQ-031 SHALL instantiate the output FIFO as the sub-module sync_fifo (show-ahead, registered output, synchronous reset).

Verification
REQ-032 SHALL verify that UB[0x10]=10 with zp=2, scale=0x0180 and length=1 gives out_data=12, out_last=1 and done, with first out_valid 5 cycles after ub_rd_en.
REQ-033 SHALL verify that q=-128, zp=127, scale=0x7FFF gives out_data=-32639, and that q=127, zp=-128, scale=0x7FFF gives out_data=32639.
REQ-034 SHALL verify that length=20 with out_ready toggled randomly delivers 20 in-order results, with outstanding never exceeding 8 and no drop or duplicate.
REQ-035 SHALL verify that base_addr=0xFE with length=4 reads addresses FE, FF, 00, 01.
REQ-036 SHALL verify that start with length=0 gives done the next cycle with no ub_rd_en, and that start while busy is ignored.
REQ-037 SHALL verify that reset asserted during DRAIN gives out_valid=0 next cycle, busy=0 and no done, and that a new transfer then completes correctly.
